// File: rtl/fetch_sequencer_pkg.sv
// Shared core definitions for the instruction fetch sequencer: FSM encodings,
// the sequential-fetch stride and the NOP word substituted for flushed returns.
package fetch_sequencer_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   localparam int unsigned PC_INCREMENT = 4;
   localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

endpackage : fetch_sequencer_pkg

// File: rtl/fetch_sequencer_next_pc_select.sv
// Next-pc priority mux: start, then branch redirect (RUN only), then stall
// hold, then sequential advance on an accepted request; otherwise hold.
module next_pc_select
   import fetch_sequencer_pkg::*;
#(
   parameter int unsigned ADDRESS_BITS = 32
) (
   input  logic                    i_start,
   input  logic [ADDRESS_BITS-1:0] i_program_address,
   input  logic                    i_run,
   input  logic                    i_branch_valid,
   input  logic [ADDRESS_BITS-1:0] i_branch_target,
   input  logic                    i_stall,
   input  logic                    i_accepted,
   input  logic [ADDRESS_BITS-1:0] i_pc,
   output logic [ADDRESS_BITS-1:0] o_next_pc
);

   // NOTE: o_next_pc gets a default first so no path through the if-chain can
   // leave it unassigned and infer a latch.
   always_comb begin
      o_next_pc = i_pc;
      if (i_start) begin
         o_next_pc = i_program_address;
      end else if (i_run && i_branch_valid) begin
         o_next_pc = i_branch_target;
      end else if (i_stall) begin
         o_next_pc = i_pc;
      end else if (i_accepted) begin
         // Address arithmetic wraps naturally at the port width.
         o_next_pc = i_pc + ADDRESS_BITS'(PC_INCREMENT);
      end
   end

endmodule : next_pc_select

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues one request per RUN cycle to a memory with
// fixed one-cycle return latency and tags each return with its PC and a flush bit.
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter int unsigned             ADDRESS_BITS = 32,
   parameter logic [ADDRESS_BITS-1:0] RESET_PC     = '0
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   input  logic [ADDRESS_BITS-1:0] program_address,
   input  logic                    stall,
   input  logic                    branch_valid,
   input  logic [ADDRESS_BITS-1:0] branch_target,
   input  logic                    i_mem_ready,
   output logic                    i_mem_read,
   output logic [ADDRESS_BITS-1:0] i_mem_read_address,
   output logic [ADDRESS_BITS-1:0] issue_PC,
   output logic                    flush_out
);

   state_e                  r_state;
   state_e                  w_state_next;
   logic [ADDRESS_BITS-1:0] r_pc;
   logic [ADDRESS_BITS-1:0] r_issue_pc;
   logic                    r_flush;
   logic [ADDRESS_BITS-1:0] w_next_pc;
   logic                    w_run;
   logic                    w_accepted;
   logic                    w_kill;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of block ordering.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      if (start) begin
         w_state_next = ST_RUN;
      end
   end

   // Read is a pure function of state, never of i_mem_ready.
   assign w_run      = (r_state == ST_RUN);
   assign i_mem_read = w_run;
   assign w_accepted = i_mem_read && i_mem_ready;
   assign w_kill     = start || branch_valid;

   // A stall without a redirect re-fetches the word last sent.
   assign i_mem_read_address = (w_run && stall && !branch_valid) ? r_issue_pc : r_pc;

   next_pc_select #(
      .ADDRESS_BITS (ADDRESS_BITS)
   ) u_next_pc_select (
      .i_start           (start),
      .i_program_address (program_address),
      .i_run             (w_run),
      .i_branch_valid    (branch_valid),
      .i_branch_target   (branch_target),
      .i_stall           (stall),
      .i_accepted        (w_accepted),
      .i_pc              (r_pc),
      .o_next_pc         (w_next_pc)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_pc       <= RESET_PC;
         r_issue_pc <= RESET_PC;
         r_flush    <= 1'b1;
      end else begin
         r_pc    <= w_next_pc;
         r_flush <= !(w_accepted && !w_kill);
         if (w_accepted) begin
            r_issue_pc <= i_mem_read_address;
         end
      end
   end

   assign issue_PC  = r_issue_pc;
   assign flush_out = r_flush;

endmodule : fetch_sequencer

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: request-side outputs are checked each cycle,
// and the expected return (issue_PC, flush_out) is queued and compared a cycle later.
module tb_fetch_sequencer;

   logic        clock;
   logic        reset;
   logic        start;
   logic [31:0] program_address;
   logic        stall;
   logic        branch_valid;
   logic [31:0] branch_target;
   logic        i_mem_ready;
   logic        i_mem_read;
   logic [31:0] i_mem_read_address;
   logic [31:0] issue_PC;
   logic        flush_out;

   typedef struct {
      logic [31:0] issue;
      logic        flush;
   } ret_t;

   ret_t        ret_q[$];
   logic [31:0] last_issue;
   int          n_checks;
   int          n_fails;

   fetch_sequencer #(
      .ADDRESS_BITS (32),
      .RESET_PC     (32'h0)
   ) dut (
      .clock              (clock),
      .reset              (reset),
      .start              (start),
      .program_address    (program_address),
      .stall              (stall),
      .branch_valid       (branch_valid),
      .branch_target      (branch_target),
      .i_mem_ready        (i_mem_ready),
      .i_mem_read         (i_mem_read),
      .i_mem_read_address (i_mem_read_address),
      .issue_PC           (issue_PC),
      .flush_out          (flush_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic pop_check();
      ret_t r;
      if (ret_q.size() == 0) begin
         n_checks++;
         n_fails++;
         $error("FAIL scoreboard_empty: observed 0 entries expected 1");
      end else begin
         r = ret_q.pop_front();
         check("issue_PC", issue_PC, r.issue);
         check("flush_out", {31'b0, flush_out}, {31'b0, r.flush});
      end
   endtask

   // One clock cycle: drive, check the request side at the falling edge, queue the
   // expected return, then compare it just after the rising edge.
   task automatic step(input logic st, input logic [31:0] pa, input logic stl,
                       input logic bv, input logic [31:0] bt, input logic rdy,
                       input logic exp_rd, input logic [31:0] exp_addr,
                       input logic exp_flush);
      ret_t r;
      start           = st;
      program_address = pa;
      stall           = stl;
      branch_valid    = bv;
      branch_target   = bt;
      i_mem_ready     = rdy;
      @(negedge clock);
      check("i_mem_read", {31'b0, i_mem_read}, {31'b0, exp_rd});
      check("i_mem_read_address", i_mem_read_address, exp_addr);
      if (exp_rd && rdy) last_issue = exp_addr;
      r.issue = last_issue;
      r.flush = exp_flush;
      ret_q.push_back(r);
      @(posedge clock);
      #1;
      pop_check();
   endtask

   initial begin
      n_checks        = 0;
      n_fails         = 0;
      last_issue      = 32'h0;
      reset           = 1'b1;
      start           = 1'b0;
      program_address = 32'h0;
      stall           = 1'b0;
      branch_valid    = 1'b0;
      branch_target   = 32'h0;
      i_mem_ready     = 1'b0;
      #2 reset = 1'b0;
      #1;
      check("rst_i_mem_read", {31'b0, i_mem_read}, 32'h0);
      check("rst_address", i_mem_read_address, 32'h0);
      check("rst_issue_PC", issue_PC, 32'h0);
      check("rst_flush_out", {31'b0, flush_out}, 32'h1);
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;

      // IDLE ignores stall and branch; start then loads 0x100.
      step(0, 32'h0,   1, 1, 32'h300, 1, 0, 32'h0,   1);
      step(1, 32'h100, 0, 0, 32'h0,   1, 0, 32'h0,   1);
      // Sequential fetch, then a redirect killing the 0x108 return.
      step(0, 32'h0,   0, 0, 32'h0,   1, 1, 32'h100, 0);
      step(0, 32'h0,   0, 0, 32'h0,   1, 1, 32'h104, 0);
      step(0, 32'h0,   0, 1, 32'h200, 1, 1, 32'h108, 1);
      step(0, 32'h0,   0, 0, 32'h0,   1, 1, 32'h200, 0);
      // Restart while running kills the 0x204 request.
      step(1, 32'h100, 0, 0, 32'h0,   1, 1, 32'h204, 1);
      step(0, 32'h0,   0, 0, 32'h0,   1, 1, 32'h100, 0);
      step(0, 32'h0,   0, 0, 32'h0,   1, 1, 32'h104, 0);
      // Three stall cycles refetch 0x104; release sends 0x108.
      step(0, 32'h0,   1, 0, 32'h0,   1, 1, 32'h104, 0);
      step(0, 32'h0,   1, 0, 32'h0,   1, 1, 32'h104, 0);
      step(0, 32'h0,   1, 0, 32'h0,   1, 1, 32'h104, 0);
      step(0, 32'h0,   0, 0, 32'h0,   1, 1, 32'h108, 0);
      // Memory not ready for two cycles at 0x10C.
      step(0, 32'h0,   0, 0, 32'h0,   0, 1, 32'h10C, 1);
      step(0, 32'h0,   0, 0, 32'h0,   0, 1, 32'h10C, 1);
      step(0, 32'h0,   0, 0, 32'h0,   1, 1, 32'h10C, 0);

      // Reset mid-cycle while 0x110 is on the bus.
      start = 1'b0; stall = 1'b0; branch_valid = 1'b0; i_mem_ready = 1'b1;
      @(negedge clock);
      check("pre_reset_address", i_mem_read_address, 32'h110);
      reset = 1'b0;
      #1;
      check("midrst_i_mem_read", {31'b0, i_mem_read}, 32'h0);
      check("midrst_address", i_mem_read_address, 32'h0);
      check("midrst_issue_PC", issue_PC, 32'h0);
      check("midrst_flush_out", {31'b0, flush_out}, 32'h1);
      @(posedge clock);
      #1 reset = 1'b1;
      ret_q.delete();
      last_issue = 32'h0;

      // Stays idle until a fresh start; then pc wraps past 0xFFFFFFFC.
      step(0, 32'h0,        0, 0, 32'h0,  1, 0, 32'h0,        1);
      step(1, 32'hFFFFFFF8, 0, 0, 32'h0,  1, 0, 32'h0,        1);
      step(0, 32'h0,        0, 0, 32'h0,  1, 1, 32'hFFFFFFF8, 0);
      step(0, 32'h0,        0, 0, 32'h0,  1, 1, 32'hFFFFFFFC, 0);
      step(0, 32'h0,        0, 0, 32'h0,  1, 1, 32'h0,        0);
      // Branch together with stall: branch wins, address is pc, request killed.
      step(0, 32'h0,        1, 1, 32'h40, 1, 1, 32'h4,        1);
      step(0, 32'h0,        0, 0, 32'h0,  1, 1, 32'h40,       0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule : tb_fetch_sequencer
